ps2_key_rx: RTL and testbench
=============================

Name: ps2_key_rx

Overview:
- PS/2 keyboard receiver on the device-to-host path.
- Deserialises 11-bit frames from the keyboard and checks them.
- Interprets the E0 (extended) and F0 (break) prefixes and holds the scan code of the currently pressed key.
- key_code drives the existing scan-code-to-control decoder directly: 8'h00 means no key held, and a held code stays stable until its break sequence arrives.

Parameters:
- FILTER_LEN, 8: consecutive equal ps2_clk samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered falling edge before a partial frame is aborted (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from pin; asynchronous.
- ps2_data  in  1  raw PS/2 data from pin; asynchronous.
- key_code  out  8  scan code of held key; 8'h00 when none.
- key_ext  out  1  held key was E0-prefixed; 0 when none.
- code_valid  out  1  one-cycle pulse when key_code is loaded by a make code, including typematic repeats.
- scan_byte  out  8  last correctly framed raw byte.
- byte_valid  out  1  one-cycle pulse when scan_byte updates.
- parity_err  out  1  one-cycle pulse: frame discarded, parity wrong.
- frame_err  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all outputs 0; FSM IDLE; bit counter 0; timeout counter 0.
  - ext/brk flags 0; filtered clock and both synchroniser stages set to 1 (idle bus).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - The filter counter counts consecutive synced ps2_clk samples that differ from the filtered level; the filtered level flips when the count reaches FILTER_LEN-1; any equal sample clears the count.
  - fall = filtered level goes 1->0. The synced ps2_data is sampled in the fall cycle.
- Frame FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with count=0. data=1 -> frame_err pulse, stay IDLE.
  - DATA: shift in LSB first; after the 8th bit (count=7) -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP:
    - data=1 and odd parity over the 8 data bits + parity bit holds -> byte accepted.
    - data=1 with even parity -> parity_err pulse, flags ext/brk cleared.
    - data=0 -> frame_err pulse; flags unchanged.
    - All three cases return to IDLE.
- Timeout:
  - The counter clears on every fall and in IDLE, and otherwise increments.
  - Reaching TIMEOUT_CYCLES while not IDLE -> IDLE, frame_err pulse, shift register discarded, flags unchanged.
  - Timeout and fall in the same cycle: fall wins, counter clears.
- Byte accept timing: all outputs below update in the cycle after the stop-bit fall cycle, i.e. register latency 1 from the fall detection.
  - scan_byte loads the byte and byte_valid pulses for every accepted byte.
  - 8'hE0: ext<=1.
  - 8'hF0: brk<=1.
  - Other byte, brk=1:
    - If the byte equals key_code and ext equals key_ext, then key_code<=0 and key_ext<=0.
    - Otherwise the held key is unchanged.
    - ext and brk are cleared; no code_valid.
  - Other byte, brk=0: key_code<=byte, key_ext<=ext, code_valid pulse, ext cleared.
- Only one key is tracked; a new make code replaces the held one (last-pressed wins).
- Pulses never last longer than one cycle. byte_valid and code_valid may coincide; error pulses never coincide with byte_valid.
- rst asserted mid-frame aborts the frame immediately with no error pulse.

Test Plan:
- Make code: frame for 8'h1D (bits 1,0,1,1,1,0,0,0, parity 1, stop 1) -> byte_valid, scan_byte=1D, code_valid, key_code=1D, key_ext=0 one cycle after the stop-bit fall.
- Break sequence: then send F0,1D -> byte_valid twice, no code_valid, key_code=00 after the 1D frame.
- Extended key: send E0,75 -> key_code=75, key_ext=1. Send E0,F0,75 -> key_code=00, key_ext=0. Send F0,75 without E0 while E0-75 is held -> key_code stays 75.
- Parity error: 8'h5A sent with even parity -> parity_err one cycle, no byte_valid, key_code unchanged. A following E0 flag set before the bad frame must be cleared.
- Framing:
  - start bit 1 -> frame_err, FSM IDLE.
  - stop bit 0 on 8'h29 -> frame_err, no byte_valid.
  - abandon after 4 bits, wait TIMEOUT_CYCLES -> frame_err; next full 8'h66 frame decodes correctly.
- Glitch/reset:
  - ps2_clk low pulse of FILTER_LEN-2 cycles -> no bit sampled.
  - rst during bit 5 of a frame -> all outputs 0, no error pulse; next 8'h76 frame decodes to key_code=76.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: conditions the bus, deserialises frames and
// tracks the currently held key through E0/F0 prefix handling.
module ps2_key_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_code_valid,
    output logic [7:0] o_scan_byte,
    output logic       o_byte_valid,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_filt;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_tcnt;
    state_t        r_state;
    logic [2:0]    r_bcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_ext;
    logic          r_brk;

    logic w_diff;
    logic w_fall;
    logic w_to;
    logic w_par_ok;

    assign w_diff   = r_clk_s2 != r_filt;
    assign w_fall   = w_diff && (r_fcnt == FMAX) && r_filt;
    assign w_to     = !w_fall && (r_state != S_IDLE) && (r_tcnt == TMAX);
    assign w_par_ok = ^{r_shift, r_par};

    // Synchronisers and ps2_clk glitch filter; idle bus level is high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (w_diff) begin
                if (r_fcnt == FMAX) begin
                    r_filt <= ~r_filt;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tcnt <= '0;
        end else if (w_fall || w_to || r_state == S_IDLE) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            o_key_code   <= '0;
            o_key_ext    <= 1'b0;
            o_code_valid <= 1'b0;
            o_scan_byte  <= '0;
            o_byte_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_code_valid <= 1'b0;
            o_byte_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            if (w_fall) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state <= S_DATA;
                            r_bcnt  <= '0;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        r_bcnt  <= r_bcnt + 1'b1;
                        if (r_bcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!r_dat_s2) begin
                            o_frame_err <= 1'b1;
                        end else if (!w_par_ok) begin
                            o_parity_err <= 1'b1;
                            r_ext        <= 1'b0;
                            r_brk        <= 1'b0;
                        end else begin
                            o_scan_byte  <= r_shift;
                            o_byte_valid <= 1'b1;
                            if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else if (r_brk) begin
                                // Release only if it names the held key
                                if (r_shift == o_key_code &&
                                    r_ext == o_key_ext) begin
                                    o_key_code <= '0;
                                    o_key_ext  <= 1'b0;
                                end
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                            end else begin
                                o_key_code   <= r_shift;
                                o_key_ext    <= r_ext;
                                o_code_valid <= 1'b1;
                                r_ext        <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_to) begin
                r_state     <= S_IDLE;
                r_shift     <= '0;
                o_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed and randomized frames for ps2_key_rx against a key-tracking
// reference model.
module tb_ps2_key_rx;

    localparam int FL = 8;
    localparam int TO = 3000;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       code_valid;
    logic [7:0] scan_byte;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;

    ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_ps2_clk(ps2_clk),
        .i_ps2_data(ps2_data),
        .o_key_code(key_code),
        .o_key_ext(key_ext),
        .o_code_valid(code_valid),
        .o_scan_byte(scan_byte),
        .o_byte_valid(byte_valid),
        .o_parity_err(parity_err),
        .o_frame_err(frame_err)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_fall = 0;
    int bv_cyc = 0;
    int n_bv = 0, n_cv = 0, n_pe = 0, n_fe = 0;

    // model state
    logic [7:0] m_key = 8'h00;
    logic       m_kext = 1'b0;
    logic [7:0] m_scan = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_bv++;
            bv_cyc = cyc;
        end
        if (code_valid) n_cv++;
        if (parity_err) n_pe++;
        if (frame_err) n_fe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            t_fall = cyc;
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b,
                                       input bit bp, input bit bs);
        logic par;
        par = ~(^b) ^ bp;
        return {~bs, par, b, 1'b0};
    endfunction

    task automatic do_frame(input string tag, input logic [7:0] b,
                            input bit bp, input bit bs);
        int s_bv, s_cv, s_pe, s_fe;
        int e_bv, e_cv, e_pe, e_fe;
        s_bv = n_bv; s_cv = n_cv; s_pe = n_pe; s_fe = n_fe;
        e_bv = 0; e_cv = 0; e_pe = 0; e_fe = 0;
        if (bs) begin
            e_fe = 1;
        end else if (bp) begin
            e_pe = 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            e_bv = 1;
            m_scan = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (m_brk) begin
                if (b == m_key && m_ext == m_kext) begin
                    m_key = 8'h00;
                    m_kext = 1'b0;
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else begin
                m_key = b;
                m_kext = m_ext;
                e_cv = 1;
                m_ext = 1'b0;
            end
        end
        send_bits(mk(b, bp, bs), 11);
        chk({tag, "_bv"}, n_bv - s_bv, e_bv);
        chk({tag, "_cv"}, n_cv - s_cv, e_cv);
        chk({tag, "_pe"}, n_pe - s_pe, e_pe);
        chk({tag, "_fe"}, n_fe - s_fe, e_fe);
        chk({tag, "_scan"}, {24'h0, scan_byte}, {24'h0, m_scan});
        chk({tag, "_key"}, {24'h0, key_code}, {24'h0, m_key});
        chk({tag, "_ext"}, {31'h0, key_ext}, {31'h0, m_kext});
    endtask

    initial begin
        int s_fe, s_pe, s_bv;
        logic [7:0] codes [4];
        logic [7:0] b;
        int pick, err;
        codes[0] = 8'h1C; codes[1] = 8'h1D;
        codes[2] = 8'h75; codes[3] = 8'h6B;

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_key", {24'h0, key_code}, 32'h0);
        chk("rst_ext", {31'h0, key_ext}, 32'h0);
        chk("rst_scan", {24'h0, scan_byte}, 32'h0);
        chk("rst_pulses",
            {28'h0, byte_valid, code_valid, parity_err, frame_err}, 32'h0);
        @(posedge clk);
        #1;

        do_frame("make1d", 8'h1D, 0, 0);
        chk("latency", bv_cyc - t_fall, 2 + FL);
        do_frame("brk_f0", 8'hF0, 0, 0);
        do_frame("brk_1d", 8'h1D, 0, 0);

        do_frame("ext_e0", 8'hE0, 0, 0);
        do_frame("ext_75", 8'h75, 0, 0);
        do_frame("xb_e0", 8'hE0, 0, 0);
        do_frame("xb_f0", 8'hF0, 0, 0);
        do_frame("xb_75", 8'h75, 0, 0);
        do_frame("re_e0", 8'hE0, 0, 0);
        do_frame("re_75", 8'h75, 0, 0);
        do_frame("nb_f0", 8'hF0, 0, 0);
        do_frame("nb_75", 8'h75, 0, 0);

        do_frame("pe_e0", 8'hE0, 0, 0);
        do_frame("pe_5a", 8'h5A, 1, 0);
        do_frame("pe_ok", 8'h5A, 0, 0);

        s_fe = n_fe;
        send_bits(11'h7FF, 1);
        chk("start1_fe", n_fe - s_fe, 1);
        do_frame("stop0", 8'h29, 0, 1);

        s_fe = n_fe;
        s_bv = n_bv;
        send_bits(mk(8'h66, 0, 0), 5);
        repeat (TO + 100) @(posedge clk);
        #1;
        chk("to_fe", n_fe - s_fe, 1);
        chk("to_bv", n_bv - s_bv, 0);
        do_frame("after_to", 8'h66, 0, 0);

        s_fe = n_fe;
        ps2_clk = 1'b0;
        repeat (FL - 2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (4 * FL) @(posedge clk);
        #1;
        chk("glitch_fe", n_fe - s_fe, 0);
        do_frame("after_gl", 8'h1C, 0, 0);

        s_fe = n_fe;
        s_pe = n_pe;
        send_bits(mk(8'h76, 0, 0), 6);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_key = 8'h00; m_kext = 1'b0; m_scan = 8'h00;
        m_ext = 1'b0; m_brk = 1'b0;
        @(negedge clk);
        chk("mrst_key", {24'h0, key_code}, 32'h0);
        chk("mrst_scan", {24'h0, scan_byte}, 32'h0);
        chk("mrst_err", (n_fe - s_fe) + (n_pe - s_pe), 0);
        @(posedge clk);
        #1;
        do_frame("post_rst", 8'h76, 0, 0);

        for (int k = 0; k < 30; k++) begin
            pick = $urandom_range(0, 9);
            err = $urandom_range(0, 9);
            if (pick < 2) b = 8'hE0;
            else if (pick < 4) b = 8'hF0;
            else if (pick < 8) b = codes[$urandom_range(0, 3)];
            else b = 8'($urandom_range(0, 255));
            do_frame("rnd", b, err == 0, err == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
